// File: rtl/do_receiver.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// do_receiver
//   Receive end of the LWC DO port. Consumes the do_* stream, assembles 32-bit
//   segment headers and the final status word (MSB first, BUSW/8 bytes per
//   beat), strips them, and forwards segment payload with byte enables.
//   Pad bytes beyond the segment length are dropped.
//
// Parameters
//   BUSW        DO bus width: 8, 16 or 32
//
// Ports
//   clk         clock, all logic on posedge
//   rst         synchronous reset, active low
//   do_data     DO data, byte 0 in [BUSW-1:BUSW-8]
//   do_valid    DO beat valid
//   do_last     DO last beat of the operation (ends the status word)
//   do_ready    DO beat accepted when do_valid & do_ready
//   hdr_valid   one-cycle pulse: segment header decoded
//   seg_type    header [31:28], held until the next header
//   seg_flags   header [27:24], held
//   seg_len     header [15:0] byte count, held
//   pld_data    payload data (pass-through of do_data in a segment)
//   pld_keep    payload byte enables, MSB byte first
//   pld_valid   payload beat valid
//   pld_ready   payload sink ready
//   pld_last    final beat of the current segment
//   stat_valid  one-cycle pulse: status word received
//   stat_ok     1 = success (0xE), 0 = failure (0xF), held until next status
//   err         sticky protocol error, cleared only by reset
// -----------------------------------------------------------------------------
module do_receiver #(
    parameter int BUSW = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BUSW-1:0]     do_data,
    input  logic                do_valid,
    input  logic                do_last,
    output logic                do_ready,
    output logic                hdr_valid,
    output logic [3:0]          seg_type,
    output logic [3:0]          seg_flags,
    output logic [15:0]         seg_len,
    output logic [BUSW-1:0]     pld_data,
    output logic [BUSW/8-1:0]   pld_keep,
    output logic                pld_valid,
    input  logic                pld_ready,
    output logic                pld_last,
    output logic                stat_valid,
    output logic                stat_ok,
    output logic                err
);

    localparam int NB     = BUSW / 8;
    localparam int HBEATS = 32 / BUSW;
    localparam int CW     = (HBEATS > 1) ? $clog2(HBEATS) : 1;

    localparam logic [3:0] T_PT   = 4'h4;
    localparam logic [3:0] T_CT   = 4'h5;
    localparam logic [3:0] T_TAG  = 4'h8;
    localparam logic [3:0] T_OK   = 4'hE;
    localparam logic [3:0] T_FAIL = 4'hF;

    typedef enum logic [1:0] {
        S_HDR = 2'd0,
        S_PLD = 2'd1,
        S_ERR = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [31:0]     hdr_q;
    logic [15:0]     rem_q;
    logic            hdr_valid_q;
    logic            stat_valid_q;
    logic            stat_ok_q;
    logic [3:0]      seg_type_q;
    logic [3:0]      seg_flags_q;
    logic [15:0]     seg_len_q;
    logic            err_q;

    logic [31:0]     hdr_d;
    logic [15:0]     rem_d;
    logic            word_done;
    logic            seg_end;
    logic            in_pld;

    // Remaining-byte decrement that clamps at zero instead of wrapping.
    function automatic logic [15:0] sat_sub(input logic [15:0] rem);
        logic [15:0] r;
        r = '0;
        if (rem > 16'(NB)) begin
            r = rem - 16'(NB);
        end
        return r;
    endfunction

    // Byte enables for the current beat: full bus unless fewer than NB bytes
    // remain, in which case only the top 'rem' byte lanes are valid.
    function automatic logic [NB-1:0] keep_mask(input logic [15:0] rem);
        logic [NB-1:0] m;
        m = '1;
        if (rem < 16'(NB)) begin
            m = ~({NB{1'b1}} >> rem);
        end
        return m;
    endfunction

    // New bytes enter at the bottom so the first byte received ends up in
    // [31:24]. For a 32-bit bus the shift discards the old word entirely.
    assign hdr_d     = (hdr_q << BUSW) | 32'(do_data);
    assign word_done = (cnt_q == CW'(HBEATS - 1));
    assign rem_d     = sat_sub(rem_q);
    assign seg_end   = (rem_q <= 16'(NB));

    // Outputs are forced quiet while rst is asserted, before the edge lands.
    assign in_pld     = rst && (state_q == S_PLD);
    assign do_ready   = rst && ((state_q == S_PLD) ? pld_ready : 1'b1);
    assign pld_valid  = in_pld && do_valid && !do_last;
    assign pld_data   = in_pld ? do_data : '0;
    assign pld_keep   = in_pld ? keep_mask(rem_q) : '0;
    assign pld_last   = in_pld && seg_end;

    assign hdr_valid  = hdr_valid_q;
    assign seg_type   = seg_type_q;
    assign seg_flags  = seg_flags_q;
    assign seg_len    = seg_len_q;
    assign stat_valid = stat_valid_q;
    assign stat_ok    = stat_ok_q;
    assign err        = err_q;

    // Header assembly register: partial words are invalidated through cnt_q,
    // so the data itself needs no reset.
    always_ff @(posedge clk) begin
        if (state_q == S_HDR && do_valid) begin
            hdr_q <= hdr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_HDR;
            cnt_q        <= '0;
            rem_q        <= '0;
            hdr_valid_q  <= 1'b0;
            stat_valid_q <= 1'b0;
            stat_ok_q    <= 1'b0;
            seg_type_q   <= '0;
            seg_flags_q  <= '0;
            seg_len_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            hdr_valid_q  <= 1'b0;
            stat_valid_q <= 1'b0;
            case (state_q)
                S_HDR: begin
                    if (do_valid) begin
                        if (!word_done) begin
                            cnt_q <= cnt_q + CW'(1);
                            if (do_last) begin
                                state_q <= S_ERR;
                                err_q   <= 1'b1;
                            end
                        end else begin
                            cnt_q <= '0;
                            if (hdr_d[31:28] == T_OK || hdr_d[31:28] == T_FAIL) begin
                                // The status word must close the operation.
                                if (do_last) begin
                                    stat_valid_q <= 1'b1;
                                    stat_ok_q    <= (hdr_d[31:28] == T_OK);
                                end else begin
                                    state_q <= S_ERR;
                                    err_q   <= 1'b1;
                                end
                            end else if (hdr_d[31:28] == T_PT || hdr_d[31:28] == T_CT ||
                                         hdr_d[31:28] == T_TAG) begin
                                if (do_last) begin
                                    state_q <= S_ERR;
                                    err_q   <= 1'b1;
                                end else begin
                                    hdr_valid_q <= 1'b1;
                                    seg_type_q  <= hdr_d[31:28];
                                    seg_flags_q <= hdr_d[27:24];
                                    seg_len_q   <= hdr_d[15:0];
                                    // An empty segment has no payload beats.
                                    if (hdr_d[15:0] != 16'd0) begin
                                        rem_q   <= hdr_d[15:0];
                                        state_q <= S_PLD;
                                    end
                                end
                            end else begin
                                state_q <= S_ERR;
                                err_q   <= 1'b1;
                            end
                        end
                    end
                end
                S_PLD: begin
                    // do_last inside a segment is fatal even if the sink stalls.
                    if (do_valid && do_last) begin
                        state_q <= S_ERR;
                        err_q   <= 1'b1;
                    end else if (do_valid && pld_ready) begin
                        rem_q <= rem_d;
                        if (seg_end) begin
                            state_q <= S_HDR;
                        end
                    end
                end
                S_ERR: begin
                    err_q <= 1'b1;
                end
                default: begin
                    state_q <= S_ERR;
                    err_q   <= 1'b1;
                end
            endcase
        end
    end

endmodule
